// File: rtl/md5_iter_core.sv
// md5_iter_core: iterative MD5 compression core with message chaining.
//
// Accepts one padded 512-bit block per transaction and runs the 64 MD5 steps
// over 64/STEPS_PER_CYCLE clocks. The chaining value (A..D) is reloaded with
// the IV on block_first and carried between blocks otherwise. A digest
// carrying the user tag is presented once the block marked block_last has
// been compressed.
//
// Parameters:
//   STEPS_PER_CYCLE  MD5 steps per clock (1, 2, 4, 8 or 16)
//   TAG_WIDTH        width of the user tag
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous reset, active low
//   block_ready   core idle, can accept a block
//   block_valid   block_data/first/last/tag valid
//   block_data    padded block, bits [511:504] hold message byte 0
//   block_first   block starts a message (chaining reloaded with IV)
//   block_last    block ends a message (digest emitted)
//   block_tag     user tag, returned with the digest
//   digest_ready  consumer accepts the digest
//   digest_valid  digest_data/digest_tag valid
//   digest_data   final digest
//   digest_tag    tag of the digested message
//   busy          core in RUN or DONE
//
// Build option:
//   MD5_CANONICAL_DIGEST_EN  when defined, digest_data is the standard MD5
//                            byte string (A byte-reversed in [127:96]);
//                            otherwise {D,C,B,A} with A in [31:0].
module md5_iter_core #(
    parameter int unsigned STEPS_PER_CYCLE = 1,
    parameter int unsigned TAG_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 block_ready,
    input  logic                 block_valid,
    input  logic [511:0]         block_data,
    input  logic                 block_first,
    input  logic                 block_last,
    input  logic [TAG_WIDTH-1:0] block_tag,
    input  logic                 digest_ready,
    output logic                 digest_valid,
    output logic [127:0]         digest_data,
    output logic [TAG_WIDTH-1:0] digest_tag,
    output logic                 busy
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BLK_W   = 512;
    localparam int unsigned DIG_W   = 128;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned N_WORDS = 16;

    localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(STEPS_PER_CYCLE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(64 - STEPS_PER_CYCLE);

    localparam logic [WORD_W-1:0] IV_A = 32'h67452301;
    localparam logic [WORD_W-1:0] IV_B = 32'hefcdab89;
    localparam logic [WORD_W-1:0] IV_C = 32'h98badcfe;
    localparam logic [WORD_W-1:0] IV_D = 32'h10325476;

    localparam logic [WORD_W-1:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Reject unsupported unroll factors at elaboration.
    if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 && STEPS_PER_CYCLE != 4 &&
        STEPS_PER_CYCLE != 8 && STEPS_PER_CYCLE != 16) begin : g_bad_steps
        $fatal(1, "md5_iter_core: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [BLK_W-1:0]     blk_q;
    logic                 last_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic [CNT_W-1:0]     step_cnt_q;
    logic [WORD_W-1:0]    a_q, b_q, c_q, d_q;
    logic [WORD_W-1:0]    a_d, b_d, c_d, d_d;
    logic [WORD_W-1:0]    ha_q, hb_q, hc_q, hd_q;
    logic [WORD_W-1:0]    sum_a, sum_b, sum_c, sum_d;
    logic [DIG_W-1:0]     digest_q, digest_d;
    logic [TAG_WIDTH-1:0] dtag_q;
    logic [WORD_W-1:0]    msg_w [N_WORDS];
    logic                 blk_accept;
    logic                 run_last;

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x,
                                               input logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

    // Per-step rotate amount: four amounts per round, cycling every step.
    function automatic logic [4:0] shift_amt(input logic [CNT_W-1:0] idx);
        logic [4:0] s;
        case ({idx[5:4], idx[1:0]})
            4'h0:    s = 5'd7;
            4'h1:    s = 5'd12;
            4'h2:    s = 5'd17;
            4'h3:    s = 5'd22;
            4'h4:    s = 5'd5;
            4'h5:    s = 5'd9;
            4'h6:    s = 5'd14;
            4'h7:    s = 5'd20;
            4'h8:    s = 5'd4;
            4'h9:    s = 5'd11;
            4'ha:    s = 5'd16;
            4'hb:    s = 5'd23;
            4'hc:    s = 5'd6;
            4'hd:    s = 5'd10;
            4'he:    s = 5'd15;
            default: s = 5'd21;
        endcase
        return s;
    endfunction

    // Message word schedule; the 4-bit arithmetic wraps mod 16 by itself.
    function automatic logic [3:0] msg_idx(input logic [CNT_W-1:0] idx);
        logic [3:0] i4;
        logic [3:0] g;
        i4 = idx[3:0];
        case (idx[5:4])
            2'd0:    g = i4;
            2'd1:    g = 4'd5 * i4 + 4'd1;
            2'd2:    g = 4'd3 * i4 + 4'd5;
            default: g = 4'd7 * i4;
        endcase
        return g;
    endfunction

    function automatic logic [WORD_W-1:0] round_f(input logic [1:0] rnd,
                                                  input logic [WORD_W-1:0] b,
                                                  input logic [WORD_W-1:0] c,
                                                  input logic [WORD_W-1:0] d);
        logic [WORD_W-1:0] f;
        case (rnd)
            2'd0:    f = (b & c) | (~b & d);
            2'd1:    f = (d & b) | (~d & c);
            2'd2:    f = b ^ c ^ d;
            default: f = c ^ (b | ~d);
        endcase
        return f;
    endfunction

`ifdef MD5_CANONICAL_DIGEST_EN
    function automatic logic [WORD_W-1:0] bswap(input logic [WORD_W-1:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction
`endif

    assign blk_accept = block_valid && (state_q == S_IDLE);
    assign run_last   = (state_q == S_RUN) && (step_cnt_q == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (block_valid) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (step_cnt_q == CNT_LAST) begin
                    state_d = last_q ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                if (digest_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake/status outputs decoded from the state register.
    always_comb begin
        block_ready  = 1'b0;
        busy         = 1'b1;
        digest_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                block_ready = 1'b1;
                busy        = 1'b0;
            end
            S_DONE:  digest_valid = 1'b1;
            default: ;
        endcase
    end

    // Little-endian word extraction; byte 0 sits in the top byte of the block.
    always_comb begin
        for (int unsigned w = 0; w < N_WORDS; w++) begin
            msg_w[w] = {blk_q[BLK_W-1-8*(4*w+3) -: 8], blk_q[BLK_W-1-8*(4*w+2) -: 8],
                        blk_q[BLK_W-1-8*(4*w+1) -: 8], blk_q[BLK_W-1-8*(4*w)   -: 8]};
        end
    end

    // STEPS_PER_CYCLE chained MD5 steps starting at step_cnt_q.
    always_comb begin : step_logic
        logic [WORD_W-1:0] wa, wb, wc, wd, t;
        logic [CNT_W-1:0]  idx;
        wa  = a_q;
        wb  = b_q;
        wc  = c_q;
        wd  = d_q;
        t   = '0;
        idx = '0;
        for (int unsigned k = 0; k < STEPS_PER_CYCLE; k++) begin
            idx = step_cnt_q + CNT_W'(k);
            t   = round_f(idx[5:4], wb, wc, wd) + wa + K_TAB[idx] + msg_w[msg_idx(idx)];
            wa  = wd;
            wd  = wc;
            wc  = wb;
            wb  = wb + rotl(t, shift_amt(idx));
        end
        a_d = wa;
        b_d = wb;
        c_d = wc;
        d_d = wd;
    end

    // Feed-forward into the chaining value after the final step.
    assign sum_a = ha_q + a_d;
    assign sum_b = hb_q + b_d;
    assign sum_c = hc_q + c_d;
    assign sum_d = hd_q + d_d;

`ifdef MD5_CANONICAL_DIGEST_EN
    assign digest_d = {bswap(sum_a), bswap(sum_b), bswap(sum_c), bswap(sum_d)};
`else
    assign digest_d = {sum_d, sum_c, sum_b, sum_a};
`endif

    // Block capture, working registers, chaining and digest registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_q      <= '0;
            last_q     <= 1'b0;
            tag_q      <= '0;
            step_cnt_q <= '0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            ha_q       <= IV_A;
            hb_q       <= IV_B;
            hc_q       <= IV_C;
            hd_q       <= IV_D;
            digest_q   <= '0;
            dtag_q     <= '0;
        end else begin
            if (blk_accept) begin
                blk_q      <= block_data;
                last_q     <= block_last;
                tag_q      <= block_tag;
                step_cnt_q <= '0;
                if (block_first) begin
                    // New message: both working and chaining values restart at IV.
                    a_q  <= IV_A;
                    b_q  <= IV_B;
                    c_q  <= IV_C;
                    d_q  <= IV_D;
                    ha_q <= IV_A;
                    hb_q <= IV_B;
                    hc_q <= IV_C;
                    hd_q <= IV_D;
                end else begin
                    a_q <= ha_q;
                    b_q <= hb_q;
                    c_q <= hc_q;
                    d_q <= hd_q;
                end
            end else if (state_q == S_RUN) begin
                a_q        <= a_d;
                b_q        <= b_d;
                c_q        <= c_d;
                d_q        <= d_d;
                step_cnt_q <= step_cnt_q + CNT_INC;
                if (run_last) begin
                    ha_q <= sum_a;
                    hb_q <= sum_b;
                    hc_q <= sum_c;
                    hd_q <= sum_d;
                    if (last_q) begin
                        digest_q <= digest_d;
                        dtag_q   <= tag_q;
                    end
                end
            end
        end
    end

    assign digest_data = digest_q;
    assign digest_tag  = dtag_q;

endmodule

// File: tb/tb_md5_iter_core.sv
// tb_md5_iter_core: scoreboard bench for md5_iter_core with a message-level
// MD5 reference model (padding, K from |sin|, chaining across blocks).
module tb_md5_iter_core;

    localparam int unsigned S  = 1;
    localparam int unsigned TW = 8;
    localparam int          K  = 64 / S;

    localparam int R_TAB [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    localparam logic [127:0] KAT_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] KAT_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] KAT_64A   = 128'h014842d480b571495a4a0363793f7367;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          block_ready;
    logic          block_valid;
    logic [511:0]  block_data;
    logic          block_first;
    logic          block_last;
    logic [TW-1:0] block_tag;
    logic          digest_ready;
    logic          digest_valid;
    logic [127:0]  digest_data;
    logic [TW-1:0] digest_tag;
    logic          busy;

    md5_iter_core #(.STEPS_PER_CYCLE(S), .TAG_WIDTH(TW)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .block_ready  (block_ready),
        .block_valid  (block_valid),
        .block_data   (block_data),
        .block_first  (block_first),
        .block_last   (block_last),
        .block_tag    (block_tag),
        .digest_ready (digest_ready),
        .digest_valid (digest_valid),
        .digest_data  (digest_data),
        .digest_tag   (digest_tag),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0]  dig;
        logic [TW-1:0] tag;
        int            acc;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        bp_en = 1'b0;
    logic [31:0] h [4];
    logic [31:0] k_tab [64];
    logic [7:0]  msg_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (bp_en) digest_ready = ($urandom_range(0, 3) != 0);
    endtask

    function automatic logic [31:0] bs(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Map a standard MD5 byte string to the port format of this build.
    function automatic logic [127:0] to_port(input logic [127:0] c);
`ifdef MD5_CANONICAL_DIGEST_EN
        return c;
`else
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[8*j +: 8] = c[127-8*j -: 8];
        return r;
`endif
    endfunction

    function automatic logic [127:0] model_canon();
        return {bs(h[0]), bs(h[1]), bs(h[2]), bs(h[3])};
    endfunction

    task automatic model_iv();
        h[0] = 32'h67452301;
        h[1] = 32'hefcdab89;
        h[2] = 32'h98badcfe;
        h[3] = 32'h10325476;
    endtask

    // MD5 compression of one block into h[].
    task automatic model_block(input logic [511:0] blk);
        logic [31:0] m [16];
        logic [31:0] a, b, c, d, f, t;
        int g, s;
        for (int w = 0; w < 16; w++) begin
            m[w] = {blk[511-8*(4*w+3) -: 8], blk[511-8*(4*w+2) -: 8],
                    blk[511-8*(4*w+1) -: 8], blk[511-8*(4*w) -: 8]};
        end
        a = h[0]; b = h[1]; c = h[2]; d = h[3];
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i;              end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * i) % 16;     end
            s = R_TAB[(i / 16) * 4 + i % 4];
            t = a + f + k_tab[i] + m[g];
            a = d; d = c; c = b;
            b = b + ((t << s) | (t >> (32 - s)));
        end
        h[0] = h[0] + a; h[1] = h[1] + b; h[2] = h[2] + c; h[3] = h[3] + d;
    endtask

    task automatic send_block(input logic [511:0] d, input logic f, input logic l,
                              input logic [TW-1:0] t, output int acc);
        int w;
        w   = 0;
        acc = -1;
        block_valid = 1'b1;
        block_data  = d;
        block_first = f;
        block_last  = l;
        block_tag   = t;
        while (!block_ready && w < 2000) begin
            step();
            w++;
        end
        check("accept_wait", block_ready, 1);
        if (block_ready) begin
            step();
            acc = cyc;
        end
        block_valid = 1'b0;
        block_data  = {16{$urandom()}};
        block_first = 1'($urandom());
        block_last  = 1'($urandom());
        block_tag   = TW'($urandom());
    endtask

    // Pad msg_q, stream its blocks, and queue the expected digest.
    task automatic send_msg(input logic [TW-1:0] tag, input logic first_on,
                            input logic use_kat, input logic [127:0] kat,
                            input logic gap_chk);
        logic [7:0]   p[$];
        logic [63:0]  bl;
        logic [511:0] blk;
        int           nb, acc, j2;
        exp_t         e;
        p  = msg_q;
        bl = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int j = 0; j < 8; j++) p.push_back(8'(bl >> (8 * j)));
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            logic fb, lb;
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
            fb = (b == 0) && first_on;
            lb = (b == nb - 1);
            if (fb) model_iv();
            model_block(blk);
            send_block(blk, fb, lb, tag, acc);
            if (lb) begin
                e.dig = use_kat ? to_port(kat) : to_port(model_canon());
                e.tag = tag;
                e.acc = acc;
                sb_q.push_back(e);
            end else if (gap_chk) begin
                j2 = 0;
                while (!block_ready && j2 < 500) begin
                    step();
                    j2++;
                end
                check("next_block_ready_cycles", 128'(j2), 128'(K));
            end
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((sb_q.size() != 0 || busy) && w < 5000) begin
            step();
            w++;
        end
        check("drain", 128'(sb_q.size() != 0 || busy), 0);
    endtask

    // Monitor: latency on rising valid, stability while stalled, scoreboard pop on handshake.
    logic          prev_v = 1'b0;
    logic          prev_stall = 1'b0;
    logic [127:0]  prev_d;
    logic [TW-1:0] prev_t;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (digest_valid && !prev_v) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_digest: got %0h expected none (cycle %0d)", digest_data, cyc);
                end else begin
                    check("latency", 128'(cyc - sb_q[0].acc), 128'(K));
                end
            end
            if (digest_valid && prev_stall) begin
                check("hold_data", digest_data, prev_d);
                check("hold_tag", 128'(digest_tag), 128'(prev_t));
            end
            if (digest_valid && digest_ready && sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("digest", digest_data, e.dig);
                check("tag", 128'(digest_tag), 128'(e.tag));
            end
            prev_v     = digest_valid;
            prev_stall = digest_valid && !digest_ready;
            prev_d     = digest_data;
            prev_t     = digest_tag;
        end
    end

    task automatic set_str(input int n, input logic [7:0] ch);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(ch);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            real v;
            v = $sin(real'(i + 1));
            if (v < 0.0) v = -v;
            k_tab[i] = 32'(longint'($floor(v * 4294967296.0)));
        end
        model_iv();
        rst_n        = 1'b0;
        block_valid  = 1'b0;
        block_data   = '0;
        block_first  = 1'b0;
        block_last   = 1'b0;
        block_tag    = '0;
        digest_ready = 1'b1;
        repeat (3) step();
        rst_n = 1'b1;
        #1;
        check("rst_block_ready", block_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_digest_valid", digest_valid, 0);
        check("rst_digest_data", digest_data, 0);
        check("rst_digest_tag", 128'(digest_tag), 0);
        step();

        // Empty message.
        msg_q.delete();
        send_msg(8'h5a, 1'b1, 1'b1, KAT_EMPTY, 1'b0);
        wait_drain();

        // "abc".
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
        send_msg(8'h3c, 1'b1, 1'b1, KAT_ABC, 1'b0);
        wait_drain();

        // 64 x 'a': two blocks, ready returns between them.
        set_str(64, 8'h61);
        send_msg(8'hc3, 1'b1, 1'b1, KAT_64A, 1'b1);
        wait_drain();

        // Backpressure: digest held 10 cycles, block_valid pulses ignored.
        digest_ready = 1'b0;
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
        send_msg(8'h77, 1'b1, 1'b1, KAT_ABC, 1'b0);
        begin
            int w;
            w = 0;
            while (!digest_valid && w < 500) begin
                step();
                w++;
            end
            check("bp_valid_seen", digest_valid, 1);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_block_ready_low", block_ready, 0);
            check("bp_valid_held", digest_valid, 1);
            block_valid = (i % 2 == 0);
            block_first = 1'b1;
            block_last  = 1'b1;
            block_data  = {16{$urandom()}};
        end
        block_valid  = 1'b0;
        step();
        digest_ready = 1'b1;
        step();
        check("bp_ready_after", block_ready, 1);
        check("bp_valid_dropped", digest_valid, 0);
        wait_drain();

        // Reset in the middle of RUN abandons the block.
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
        send_msg(8'h11, 1'b1, 1'b0, '0, 1'b0);
        repeat (K / 2) step();
        check("midrun_busy", busy, 1);
        rst_n = 1'b0;
        sb_q.delete();
        model_iv();
        #1;
        check("inreset_valid", digest_valid, 0);
        check("inreset_busy", busy, 0);
        repeat (2) step();
        rst_n = 1'b1;
        #1;
        check("postrst_block_ready", block_ready, 1);
        msg_q.delete();
        send_msg(8'h5a, 1'b1, 1'b1, KAT_EMPTY, 1'b0);
        wait_drain();

        // Non-first block straight after reset starts from IV.
        step();
        rst_n = 1'b0;
        model_iv();
        repeat (2) step();
        rst_n = 1'b1;
        msg_q.delete();
        send_msg(8'h22, 1'b0, 1'b1, KAT_EMPTY, 1'b0);
        wait_drain();

        // Random messages, random backpressure and idle gaps.
        bp_en = 1'b1;
        for (int n = 0; n < 25; n++) begin
            int len;
            len = $urandom_range(0, 130);
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom()));
            send_msg(TW'($urandom()), ($urandom_range(0, 4) != 0), 1'b0, '0, 1'b0);
            repeat ($urandom_range(0, 2)) step();
        end
        wait_drain();
        bp_en        = 1'b0;
        digest_ready = 1'b1;
        repeat (4) step();
        check("sb_empty", 128'(sb_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md5_iter_core.md
MD5_ITER_CORE -- requirements
Module: md5_iter_core

Interface
REQ-001 SHALL have parameter STEPS_PER_CYCLE, default 1: MD5 steps per clock; legal 1,2,4,8,16; other values fail elaboration ($fatal).
REQ-002 SHALL have parameter TAG_WIDTH, default 8: width of the user tag carried from block to digest.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port block_ready  output  1  core can accept a block.
REQ-006 SHALL have port block_valid  input  1  block_data/first/last/tag valid.
REQ-007 SHALL have port block_data  input  512  padded block; bits [511:504] = message byte 0.
REQ-008 SHALL have port block_first  input  1  block starts a message; chaining reloaded with IV.
REQ-009 SHALL have port block_last  input  1  block ends a message; digest emitted.
REQ-010 SHALL have port block_tag  input  TAG_WIDTH  user tag, sampled with last block.
REQ-011 SHALL have port digest_ready  input  1  consumer accepts digest.
REQ-012 SHALL have port digest_valid  output  1  digest_data/digest_tag valid.
REQ-013 SHALL have port digest_data  output  128  final digest.
REQ-014 SHALL have port digest_tag  output  TAG_WIDTH  tag of the digested message.
REQ-015 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-016 SHALL implement FSM IDLE, RUN, DONE; block_ready = (state==IDLE); busy = (state!=IDLE).
REQ-017 SHALL, in IDLE on block_valid&&block_ready, capture block_data/first/last/tag, load working A..D from IV (if first) or chaining regs (otherwise), clear step counter, enter RUN.
REQ-018 SHALL, per RUN cycle, execute STEPS_PER_CYCLE consecutive MD5 steps combinationally (standard K table, shifts, message index, little-endian word extraction from byte order of REQ-007) and advance step counter by STEPS_PER_CYCLE.
REQ-019 SHALL, on the RUN edge completing step 63, add A..D mod 2^32 into chaining regs (feed-forward); K = 64/STEPS_PER_CYCLE RUN cycles per block.
REQ-020 SHALL, at that edge, enter DONE with digest_valid=1 if captured last=1, else return to IDLE.
REQ-021 SHALL assert digest_valid exactly K cycles after the accepting edge; next block acceptable K cycles after accept for non-last blocks.
REQ-022 SHALL hold digest_data and digest_tag stable while digest_valid && !digest_ready.
REQ-023 SHALL, in DONE on digest_ready, drop digest_valid and enter IDLE; block_ready rises the following cycle (no same-cycle overlap).
REQ-024 SHALL ignore block_valid while in RUN or DONE; block inputs need not be held after acceptance.
REQ-025 SHALL treat block_first && block_last as a single-block message.
REQ-026 SHALL use IV when block_first=0 arrives with no prior block since reset (chaining regs reset to IV).
REQ-027 SHALL default digest_data = {D,C,B,A} from chaining regs (A in bits [31:0]).

Reset
REQ-028 SHALL, on reset low, asynchronously force state=IDLE, digest_valid=0, busy=0, digest_data=0, digest_tag=0, chaining regs=IV (67452301, EFCDAB89, 98BADCFE, 10325476); block_ready=1 after release.
REQ-029 SHALL abandon any in-flight block or pending digest on reset without output.

Configuration
REQ-030 SHALL support macro MD5_CANONICAL_DIGEST_EN: when defined, digest_data = byte-reversed A,B,C,D concatenated with A in bits [127:96], matching the standard hex MD5 string; when undefined, REQ-027 format.

Verification
REQ-031 SHALL test: "" (block_data=0x80 then zeros, first=last=1, tag=0x5A) -> digest_data 7e42f8ec980980e904b2008fd98c1dd4, tag 0x5A; with macro d41d8cd98f00b204e9800998ecf8427e.
REQ-032 SHALL test: "abc" (61 62 63 80 .., byte56=0x18) -> with macro 900150983cd24fb0d6963f7d28e17f72; digest_valid 64 cycles after accept at STEPS_PER_CYCLE=1, 4 at 16.
REQ-033 SHALL test: 2-block 64x"a" message (first then last) -> with macro 014842d480b571495a4a0363793f7367; block_ready high between blocks.
REQ-034 SHALL test: digest_ready held low 10 cycles -> digest_valid/data/tag stable, block_ready low, block_valid pulses ignored.
REQ-035 SHALL test: reset asserted mid-RUN -> digest_valid never asserts, block_ready=1 after release, next "" block yields REQ-031 result.
